// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a start-framed shift FSM and a
// single-slot output buffer. A word completing while the slot is full is dropped.
module sipo_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:1] sreg;
    logic [CW-1:0]    count;

    logic             last_bit;
    logic             complete;
    logic             accept;
    logic [WIDTH-1:0] word;

    // Only the upper WIDTH-1 bits are stored: the final bit arrives on
    // serial_in in the completing cycle and is merged in directly.
    assign word     = {serial_in, sreg};
    assign last_bit = (count == CW'(WIDTH - 1));
    // A start on the last bit cycle resynchronises instead of completing.
    assign complete = (state == SHIFT) && !start && last_bit;
    // Handshake: a word transfers on every edge where out_valid and out_ready
    // are both high; out_valid stays up and parallel_out stays stable until then.
    assign accept   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            sreg  <= word[WIDTH-1:1];
            count <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
        end else if (state == SHIFT) begin
            sreg <= word[WIDTH-1:1];
            if (last_bit) begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (complete && (!out_valid || accept)) begin
                parallel_out <= word;
                out_valid    <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            if (complete && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=16), including a small behavioural model
// of the upstream parallel-in/serial-out shifter for the chained scenario.
module tb_sipo_rx;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         serial_drv;
    logic         start;
    logic         out_ready;
    logic         overrun_clr;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    logic         use_piso;
    logic         piso_load;
    logic [W-1:0] piso_d;
    logic [W-1:0] piso_q;
    logic         serial_in;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_rx #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .start        (start),
        .out_ready    (out_ready),
        .overrun_clr  (overrun_clr),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream shifter model: load on an edge, then shift right one bit per edge.
    always @(posedge clk) begin
        if (piso_load) piso_q <= piso_d;
        else           piso_q <= piso_q >> 1;
    end
    assign serial_in = use_piso ? piso_q[0] : serial_drv;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting in the current cycle; returns in cycle t+W.
    task automatic drive_frame(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
            start      = (k == 0);
            serial_drv = w[k];
            tick();
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (parallel_out !== 16'h0000) begin n_fail++; $display("FAIL reset_parallel_out: got %h expected %h", parallel_out, 16'h0000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w = 16'hA5C3;
        out_ready = 1'b1;
        for (int k = 0; k < W; k++) begin
            start      = (k == 0);
            serial_drv = w[k];
            tick();
            start = 1'b0;
            // now in cycle t+k+1
            n_checks++; if (busy !== (k < W - 1)) begin n_fail++; $display("FAIL single_busy cycle t+%0d: got %b expected %b", k + 1, busy, (k < W - 1)); end
            n_checks++; if (out_valid !== (k == W - 1)) begin n_fail++; $display("FAIL single_valid cycle t+%0d: got %b expected %b", k + 1, out_valid, (k == W - 1)); end
        end
        n_checks++; if (parallel_out !== 16'hA5C3) begin n_fail++; $display("FAIL single_data: got %h expected %h", parallel_out, 16'hA5C3); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t17: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_frame(16'h1234);
        n_checks++; if (out_valid !== 1'b1 || parallel_out !== 16'h1234) begin n_fail++; $display("FAIL b2b_first: got v=%b %h expected v=1 %h", out_valid, parallel_out, 16'h1234); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun_yet: got %b expected 0", overrun); end
        drive_frame(16'hBEEF);
        n_checks++; if (parallel_out !== 16'h1234) begin n_fail++; $display("FAIL b2b_held: got %h expected %h", parallel_out, 16'h1234); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b expected 1", out_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_clr: got %b expected 0", overrun); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got %b expected 0", out_valid); end
        n_checks++; if (parallel_out !== 16'h1234) begin n_fail++; $display("FAIL b2b_data_kept: got %h expected %h", parallel_out, 16'h1234); end
    endtask

    task automatic test_accept_and_complete();
        logic [W-1:0] w;
        out_ready = 1'b0;
        drive_frame(16'h00FF);
        n_checks++; if (out_valid !== 1'b1 || parallel_out !== 16'h00FF) begin n_fail++; $display("FAIL ac_first: got v=%b %h expected v=1 %h", out_valid, parallel_out, 16'h00FF); end
        w = 16'hFF00;
        for (int k = 0; k < W; k++) begin
            start      = (k == 0);
            serial_drv = w[k];
            out_ready  = (k == W - 1);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ac_valid: got %b expected 1", out_valid); end
        n_checks++; if (parallel_out !== 16'hFF00) begin n_fail++; $display("FAIL ac_data: got %h expected %h", parallel_out, 16'hFF00); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ac_overrun: got %b expected 0", overrun); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ac_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_resync();
        logic [W-1:0] junk;
        logic [W-1:0] w;
        junk = 16'h5555;
        w    = 16'h8001;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            start      = (k == 0);
            serial_drv = junk[k];
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resync_pre_valid cycle %0d: got %b expected 0", k, out_valid); end
        end
        // new frame from t+5; covers cycle t+16 where the abandoned frame would have ended
        for (int k = 0; k < W; k++) begin
            start      = (k == 0);
            serial_drv = w[k];
            tick();
            if (k < W - 1) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resync_no_word cycle t+%0d: got %b expected 0", k + 6, out_valid); end
            end
        end
        start = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || parallel_out !== 16'h8001) begin n_fail++; $display("FAIL resync_word: got v=%b %h expected v=1 %h", out_valid, parallel_out, 16'h8001); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL resync_overrun: got %b expected 0", overrun); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resync_drain: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_chained();
        out_ready = 1'b1;
        use_piso  = 1'b1;
        piso_d    = 16'hC0DE;
        piso_load = 1'b1;
        tick();
        piso_load = 1'b0;
        start     = 1'b1;          // cycle t, piso output is bit 0
        tick();
        start = 1'b0;
        repeat (W - 2) tick();     // now in cycle t+15
        piso_d    = 16'h7E57;
        piso_load = 1'b1;
        tick();                    // cycle t+16
        piso_load = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || parallel_out !== 16'hC0DE) begin n_fail++; $display("FAIL chain_first: got v=%b %h expected v=1 %h", out_valid, parallel_out, 16'hC0DE); end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (W - 1) tick();     // cycle t+32
        n_checks++; if (out_valid !== 1'b1 || parallel_out !== 16'h7E57) begin n_fail++; $display("FAIL chain_second: got v=%b %h expected v=1 %h", out_valid, parallel_out, 16'h7E57); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL chain_overrun: got %b expected 0", overrun); end
        use_piso = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] w;
        out_ready = 1'b0;
        drive_frame(16'h3C3C);
        w = 16'h9999;
        for (int k = 0; k < 7; k++) begin
            start      = (k == 0);
            serial_drv = w[k];
            tick();
        end
        start      = 1'b0;
        serial_drv = w[7];         // in cycle t+7 (bit 7)
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmf_pre: got v=%b busy=%b expected v=1 busy=1", out_valid, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (parallel_out !== 16'h0000) begin n_fail++; $display("FAIL rmf_parallel_out: got %h expected %h", parallel_out, 16'h0000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rmf_overrun: got %b expected 0", overrun); end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            serial_drv = 1'b1;
            tick();
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmf_post cycle %0d: got v=%b busy=%b expected v=0 busy=0", k, out_valid, busy); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n       = 1'b0;
        serial_drv  = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        use_piso    = 1'b0;
        piso_load   = 1'b0;
        piso_d      = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_accept_and_complete();
        test_resync();
        test_chained();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
